// File: rtl/ethernet_rx_mmio_reader_pkg.sv
// Shared definitions for the MMIO RX frame reader: FSM states and the
// controller register map it talks to.
package ethernet_rx_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_SIZE,
        S_WAIT_SIZE,
        S_REQ_DATA,
        S_WAIT_DATA,
        S_SEND,
        S_REQ_ACK,
        S_WAIT_ACK
    } rx_state_e;

    localparam logic [13:0] RX_BUF_BASE  = 14'h0000;
    localparam logic [13:0] RX_SIZE_ADDR = 14'h1004;
    localparam logic [13:0] RX_ACK_ADDR  = 14'h1010;
    localparam int          RX_ACK_VAL   = 1;

    function automatic int safe_clog2(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/ethernet_rx_mmio_reader.sv
// Drains RX frames from ethernet_controller over its register port and streams them out.
// Optional byte-enable output pkt_keep_o is built when ETH_RX_READER_KEEP_EN is defined.
module ethernet_rx_mmio_reader
    import ethernet_rx_reader_pkg::*;
#(
    parameter int  data_width_p    = 32,
    parameter int  max_pkt_bytes_p = 2048,
    localparam int size_width_lp   = $clog2($clog2(data_width_p / 8) + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    output logic [13:0]               addr_o,
    output logic                      write_en_o,
    output logic                      read_en_o,
    input  logic                      ready_and_i,
    output logic [size_width_lp-1:0]  op_size_o,
    output logic [data_width_p-1:0]   write_data_o,
    input  logic                      valid_i,
    output logic                      ready_and_o,
    input  logic [data_width_p-1:0]   read_data_i,
    input  logic                      rx_interrupt_pending_i,
    output logic [data_width_p-1:0]   pkt_data_o,
    output logic                      pkt_v_o,
    output logic                      pkt_last_o,
    input  logic                      pkt_ready_and_i,
`ifdef ETH_RX_READER_KEEP_EN
    output logic [data_width_p/8-1:0] pkt_keep_o,
`endif
    output logic [7:0]                drop_count_o
);

    localparam int bpw_lp    = data_width_p / 8;
    localparam int lg_bpw_lp = $clog2(bpw_lp);
    localparam int idx_w_lp  = safe_clog2(max_pkt_bytes_p / bpw_lp);

    rx_state_e                 state_q, state_d;
    logic [idx_w_lp-1:0]       idx_q, idx_d;
    logic [idx_w_lp-1:0]       last_idx_q, last_idx_d;
    logic [7:0]                drop_q, drop_d;
    logic [13:0]               addr_q, addr_d;
    logic                      rd_en_q, rd_en_d;
    logic                      wr_en_q, wr_en_d;
    logic                      rdy_q, rdy_d;
    logic [data_width_p-1:0]   wdata_q, wdata_d;
    logic [data_width_p-1:0]   pkt_data_q, pkt_data_d;
    logic                      pkt_v_q, pkt_v_d;
    logic                      pkt_last_q, pkt_last_d;
    logic [15:0]               size_w;

    assign size_w = read_data_i[15:0];

`ifdef ETH_RX_READER_KEEP_EN
    logic [lg_bpw_lp-1:0] rem_q, rem_d;
    logic [bpw_lp-1:0]    keep_q, keep_d;

    // A zero remainder means the frame fills its last word completely.
    function automatic logic [bpw_lp-1:0] last_keep(input logic [lg_bpw_lp-1:0] rem);
        if (rem == '0) return '1;
        return bpw_lp'((1 << rem) - 1);
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        drop_d     = drop_q;
        pkt_data_d = pkt_data_q;
`ifdef ETH_RX_READER_KEEP_EN
        rem_d      = rem_q;
`endif
        unique case (state_q)
            S_IDLE:      if (rx_interrupt_pending_i) state_d = S_REQ_SIZE;
            S_REQ_SIZE:  if (ready_and_i) state_d = S_WAIT_SIZE;
            S_WAIT_SIZE: begin
                if (valid_i) begin
                    if (size_w == 16'd0) begin
                        state_d = S_REQ_ACK;
                    end else if (32'(size_w) > 32'(max_pkt_bytes_p)) begin
                        state_d = S_REQ_ACK;
                        drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                    end else begin
                        state_d    = S_REQ_DATA;
                        idx_d      = '0;
                        last_idx_d = idx_w_lp'((32'(size_w) - 32'd1) >> lg_bpw_lp);
`ifdef ETH_RX_READER_KEEP_EN
                        rem_d      = size_w[lg_bpw_lp-1:0];
`endif
                    end
                end
            end
            S_REQ_DATA:  if (ready_and_i) state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (valid_i) begin
                    pkt_data_d = read_data_i;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (pkt_ready_and_i) begin
                    if (idx_q == last_idx_q) begin
                        state_d = S_REQ_ACK;
                    end else begin
                        idx_d   = idx_q + idx_w_lp'(1);
                        state_d = S_REQ_DATA;
                    end
                end
            end
            S_REQ_ACK:   if (ready_and_i) state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (valid_i) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops clean.
        rd_en_d    = (state_d == S_REQ_SIZE) || (state_d == S_REQ_DATA);
        wr_en_d    = (state_d == S_REQ_ACK);
        rdy_d      = (state_d == S_WAIT_SIZE) || (state_d == S_WAIT_DATA) ||
                     (state_d == S_WAIT_ACK);
        wdata_d    = (state_d == S_REQ_ACK) ? data_width_p'(RX_ACK_VAL) : '0;
        pkt_v_d    = (state_d == S_SEND);
        pkt_last_d = (state_d == S_SEND) && (idx_d == last_idx_d);
        unique case (state_d)
            S_REQ_SIZE: addr_d = RX_SIZE_ADDR;
            S_REQ_DATA: addr_d = RX_BUF_BASE + (14'(idx_d) << lg_bpw_lp);
            S_REQ_ACK:  addr_d = RX_ACK_ADDR;
            default:    addr_d = '0;
        endcase
`ifdef ETH_RX_READER_KEEP_EN
        keep_d = '0;
        if (pkt_v_d) keep_d = pkt_last_d ? last_keep(rem_d) : '1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_idx_q <= '0;
            drop_q     <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rdy_q      <= 1'b0;
            wdata_q    <= '0;
            pkt_data_q <= '0;
            pkt_v_q    <= 1'b0;
            pkt_last_q <= 1'b0;
`ifdef ETH_RX_READER_KEEP_EN
            rem_q      <= '0;
            keep_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            rdy_q      <= rdy_d;
            wdata_q    <= wdata_d;
            pkt_data_q <= pkt_data_d;
            pkt_v_q    <= pkt_v_d;
            pkt_last_q <= pkt_last_d;
`ifdef ETH_RX_READER_KEEP_EN
            rem_q      <= rem_d;
            keep_q     <= keep_d;
`endif
        end
    end

    assign addr_o       = addr_q;
    assign read_en_o    = rd_en_q;
    assign write_en_o   = wr_en_q;
    assign ready_and_o  = rdy_q;
    assign write_data_o = wdata_q;
    assign op_size_o    = size_width_lp'(lg_bpw_lp);
    assign pkt_data_o   = pkt_data_q;
    assign pkt_v_o      = pkt_v_q;
    assign pkt_last_o   = pkt_last_q;
    assign drop_count_o = drop_q;
`ifdef ETH_RX_READER_KEEP_EN
    assign pkt_keep_o   = keep_q;
`endif

endmodule

// File: tb/tb_ethernet_rx_mmio_reader.sv
// Directed bench for ethernet_rx_mmio_reader: models the controller register port
// and a stream consumer, then checks request order, stream beats and counters.
module tb_ethernet_rx_mmio_reader;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [13:0] addr_o;
    logic        write_en_o, read_en_o, ready_and_i;
    logic [1:0]  op_size_o;
    logic [31:0] write_data_o;
    logic        valid_i, ready_and_o;
    logic [31:0] read_data_i;
    logic        rx_interrupt_pending_i;
    logic [31:0] pkt_data_o;
    logic        pkt_v_o, pkt_last_o, pkt_ready_and_i;
    logic [7:0]  drop_count_o;
`ifdef ETH_RX_READER_KEEP_EN
    logic [3:0]  pkt_keep_o;
`endif

    ethernet_rx_mmio_reader dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .addr_o                 (addr_o),
        .write_en_o             (write_en_o),
        .read_en_o              (read_en_o),
        .ready_and_i            (ready_and_i),
        .op_size_o              (op_size_o),
        .write_data_o           (write_data_o),
        .valid_i                (valid_i),
        .ready_and_o            (ready_and_o),
        .read_data_i            (read_data_i),
        .rx_interrupt_pending_i (rx_interrupt_pending_i),
        .pkt_data_o             (pkt_data_o),
        .pkt_v_o                (pkt_v_o),
        .pkt_last_o             (pkt_last_o),
        .pkt_ready_and_i        (pkt_ready_and_i),
`ifdef ETH_RX_READER_KEEP_EN
        .pkt_keep_o             (pkt_keep_o),
`endif
        .drop_count_o           (drop_count_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct { logic we; logic [13:0] addr; logic [31:0] wdata; int cyc; } req_t;
    typedef struct { logic [31:0] data; logic last; logic [3:0] keep; } beat_t;

    req_t  req_q[$];
    beat_t beat_q[$];
    int    ack_cycs[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    pcnt = 0;
    int    ack_cnt = 0;
    int    exp_drop = 0;
    logic [15:0] frame_size = 16'd0;
    bit    stall_en = 1'b0;
    bit    resp_pend = 1'b0;
    bit    resp_is_ack = 1'b0;
    logic [31:0] resp_data = '0;

    logic        p_rst = 1'b1, p_req_hold = 1'b0, p_pkt_hold = 1'b0;
    logic        p_rd = 1'b0, p_wr = 1'b0, p_plast = 1'b0;
    logic [13:0] p_addr = '0;
    logic [31:0] p_wdata = '0, p_pdata = '0;

    logic [13:0] dbl_addr [8] = '{14'h1004, 14'h0000, 14'h0004, 14'h1010,
                                  14'h1004, 14'h0000, 14'h0004, 14'h1010};
    logic        dbl_we   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [13:0] a);
        return 32'hC0DE0000 | {18'd0, a};
    endfunction

    function automatic int count_size_reads();
        int c = 0;
        foreach (req_q[i]) if (!req_q[i].we && req_q[i].addr == 14'h1004) c++;
        return c;
    endfunction

    always @(posedge clk_i) pcnt = pcnt + 1;

    // Controller responder and stream-consumer drive, one cycle of decisions each edge.
    initial begin
        ready_and_i = 1'b0; valid_i = 1'b0; read_data_i = '0; pkt_ready_and_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            ready_and_i     = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            valid_i         = resp_pend && (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
            read_data_i     = resp_data;
            pkt_ready_and_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Handshake bookkeeping and stall-stability checks, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!reset_i && !p_rst) begin
            if (p_req_hold)
                chk("req_hold", {read_en_o, write_en_o, addr_o, write_data_o},
                    {p_rd, p_wr, p_addr, p_wdata});
            if (p_pkt_hold)
                chk("pkt_hold", {pkt_v_o, pkt_last_o, pkt_data_o}, {1'b1, p_plast, p_pdata});
        end
        if (reset_i) begin
            resp_pend = 1'b0;
        end else begin
            if (valid_i && ready_and_o) begin
                resp_pend = 1'b0;
                if (resp_is_ack) begin
                    ack_cnt++;
                    ack_cycs.push_back(pcnt);
                end
            end
            if ((read_en_o || write_en_o) && ready_and_i) begin
                req_q.push_back('{we: write_en_o, addr: addr_o, wdata: write_data_o, cyc: pcnt});
                resp_pend   = 1'b1;
                resp_is_ack = write_en_o;
                if (write_en_o)              resp_data = 32'hDEADBEEF;
                else if (addr_o == 14'h1004) resp_data = 32'h5A5A0000 | {16'd0, frame_size};
                else                         resp_data = word_at(addr_o);
            end
            if (pkt_v_o && pkt_ready_and_i) begin
`ifdef ETH_RX_READER_KEEP_EN
                beat_q.push_back('{data: pkt_data_o, last: pkt_last_o, keep: pkt_keep_o});
`else
                beat_q.push_back('{data: pkt_data_o, last: pkt_last_o, keep: 4'hF});
`endif
            end
        end
        p_rst      = reset_i;
        p_req_hold = (read_en_o || write_en_o) && !ready_and_i;
        p_pkt_hold = pkt_v_o && !pkt_ready_and_i;
        p_rd = read_en_o; p_wr = write_en_o; p_addr = addr_o; p_wdata = write_data_o;
        p_plast = pkt_last_o; p_pdata = pkt_data_o;
    end

    task automatic wait_ack(input int target, input int budget);
        for (int i = 0; i < budget && ack_cnt < target; i++) begin
            @(posedge clk_i); #1;
        end
        chk("ack_seen", ack_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, read_en_o, 1'b0);
        chk({tag, "_wr_en"}, write_en_o, 1'b0);
        chk({tag, "_rdy"}, ready_and_o, 1'b0);
        chk({tag, "_pkt_v"}, pkt_v_o, 1'b0);
        chk({tag, "_pkt_last"}, pkt_last_o, 1'b0);
        chk({tag, "_addr"}, addr_o, 14'd0);
        chk({tag, "_wdata"}, write_data_o, 32'd0);
        chk({tag, "_pkt_data"}, pkt_data_o, 32'd0);
        chk({tag, "_drop"}, drop_count_o, 8'd0);
`ifdef ETH_RX_READER_KEEP_EN
        chk({tag, "_keep"}, pkt_keep_o, 4'd0);
`endif
    endtask

    task automatic run_frame(input int size);
        int n, start, base;
        logic [3:0] exp_keep;
        n = (size == 0 || size > 2048) ? 0 : (size + 3) / 4;
        if (size > 2048 && exp_drop < 255) exp_drop++;
        req_q.delete(); beat_q.delete();
        base = ack_cnt;
        @(posedge clk_i); #1;
        frame_size = 16'(size);
        rx_interrupt_pending_i = 1'b1;
        start = pcnt;
        @(posedge clk_i); #1;
        rx_interrupt_pending_i = 1'b0;
        wait_ack(base + 1, 3000);
        chk("req_count", req_q.size(), n + 2);
        if (req_q.size() == n + 2) begin
            chk("size_rd", {req_q[0].we, req_q[0].addr}, {1'b0, 14'h1004});
            for (int i = 0; i < n; i++)
                chk("data_rd", {req_q[i+1].we, req_q[i+1].addr}, {1'b0, 14'(4 * i)});
            chk("ack_wr", {req_q[n+1].we, req_q[n+1].addr, req_q[n+1].wdata},
                {1'b1, 14'h1010, 32'd1});
        end
        chk("beat_count", beat_q.size(), n);
        for (int i = 0; i < n && i < beat_q.size(); i++) begin
            chk("beat_data", beat_q[i].data, word_at(14'(4 * i)));
            chk("beat_last", beat_q[i].last, (i == n - 1));
            exp_keep = 4'hF;
`ifdef ETH_RX_READER_KEEP_EN
            if (i == n - 1 && (size % 4) != 0) exp_keep = 4'((1 << (size % 4)) - 1);
`endif
            chk("beat_keep", beat_q[i].keep, exp_keep);
        end
        chk("drop_count", drop_count_o, exp_drop);
        if (!stall_en && ack_cycs.size() > 0)
            chk("latency", ack_cycs[ack_cycs.size()-1] - start + 1, 3 * n + 5);
    endtask

    initial begin
        int  base;
        bit  found;
        reset_i = 1'b1;
        rx_interrupt_pending_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        chk("op_size", op_size_o, 2'd2);
        reset_i = 1'b0;

        run_frame(6);
        run_frame(0);
        run_frame(3000);
        for (int i = 0; i < 299; i++) run_frame(3000);
        chk("drop_sat", drop_count_o, 8'd255);

        stall_en = 1'b1;
        run_frame(64);
        stall_en = 1'b0;
        repeat (2) @(posedge clk_i);

        // Reset while the third of ten words is on the stream output.
        req_q.delete(); beat_q.delete();
        @(posedge clk_i); #1;
        frame_size = 16'd40;
        rx_interrupt_pending_i = 1'b1;
        @(posedge clk_i); #1;
        rx_interrupt_pending_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pkt_v_o && pkt_data_o == word_at(14'd8)) begin
                found = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        chk("reach_word3", found, 1'b1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        check_reset_outputs("midrst");
        reset_i = 1'b0;
        exp_drop = 0;
        run_frame(6);

        // Pending held high across the ack: second frame must start after the ack response.
        req_q.delete(); beat_q.delete(); ack_cycs.delete();
        base = ack_cnt;
        @(posedge clk_i); #1;
        frame_size = 16'd6;
        rx_interrupt_pending_i = 1'b1;
        for (int i = 0; i < 200 && count_size_reads() < 2; i++) begin
            @(posedge clk_i); #1;
        end
        rx_interrupt_pending_i = 1'b0;
        wait_ack(base + 2, 500);
        chk("dbl_req_count", req_q.size(), 8);
        if (req_q.size() == 8 && ack_cycs.size() == 2) begin
            for (int i = 0; i < 8; i++)
                chk("dbl_req", {req_q[i].we, req_q[i].addr}, {dbl_we[i], dbl_addr[i]});
            chk("dbl_gap", req_q[4].cyc - ack_cycs[0], 2);
        end
        chk("dbl_beats", beat_q.size(), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ethernet_rx_mmio_reader.md
# ethernet_rx_mmio_reader

Memory-mapped initiator that sits on the host side of `ethernet_controller`'s register port and drains received frames. On `rx_interrupt_pending_i` it reads the RX size register, reads the frame out of the controller's RX buffer one word at a time, and streams the words out with a valid/ready handshake. It then writes the RX acknowledge register to release the buffer. It is the reader counterpart to the controller's register-port responder, for use in standalone bring-up and for DMA-less NIC paths.

## Interface
- `data_width_p`, 32: MMIO and stream word width in bits; must be 32 or 64.
- `max_pkt_bytes_p`, 2048: largest legal frame, equal to the RX buffer size.
- `clk_i` in 1: the single clock for all logic.
- `reset_i` in 1: synchronous, active-high reset.
- `addr_o` out 14: request address.
- `write_en_o` out 1: write request valid.
- `read_en_o` out 1: read request valid.
- `ready_and_i` in 1: controller accepts the request this cycle.
- `op_size_o` out `size_width_lp`: fixed at clog2(data_width_p/8), i.e. full-width accesses only.
- `write_data_o` out data_width_p: write payload.
- `valid_i` in 1: response valid.
- `ready_and_o` out 1: this block accepts the response.
- `read_data_i` in data_width_p: response data.
- `rx_interrupt_pending_i` in 1: level, frame waiting.
- `pkt_data_o` out data_width_p: stream word; the lowest-addressed byte is in bits [7:0].
- `pkt_v_o` out 1: stream word valid.
- `pkt_last_o` out 1: final word of the frame.
- `pkt_ready_and_i` in 1: consumer accepts the word.
- `drop_count_o` out 8: saturating count of oversize frames dropped.

## Operation
- Every request, read or write, produces exactly one response beat. At most one request is outstanding at a time.
- Register map, defined in the package:
  - `RX_BUF_BASE` = 0x0000.
  - `RX_SIZE_ADDR` = 0x1004; bits [15:0] hold the byte count.
  - `RX_ACK_ADDR` = 0x1010; writing 1 releases the frame.
- FSM states and transitions:
  - IDLE → REQ_SIZE when `rx_interrupt_pending_i`=1.
  - REQ_SIZE: `read_en_o`=1, `addr_o`=RX_SIZE_ADDR. Moves to WAIT_SIZE on `ready_and_i`.
  - WAIT_SIZE: `ready_and_o`=1. On `valid_i`, latch the size. Then:
    - size=0 → REQ_ACK;
    - size>max_pkt_bytes_p → REQ_ACK and increment `drop_count_o` (saturating at 255);
    - otherwise words = ceil(size / (data_width_p/8)), word index = 0, → REQ_DATA.
  - REQ_DATA: `read_en_o`=1, `addr_o`=RX_BUF_BASE + index·(data_width_p/8). Moves to WAIT_DATA on `ready_and_i`.
  - WAIT_DATA: `ready_and_o`=1. On `valid_i`, capture `read_data_i` into the output register → SEND.
  - SEND: `pkt_v_o`=1, and `pkt_last_o`=1 when index=words−1. On `pkt_ready_and_i`, go to REQ_ACK if last; otherwise increment index and go to REQ_DATA.
  - REQ_ACK: `write_en_o`=1, `addr_o`=RX_ACK_ADDR, `write_data_o`=1. Moves to WAIT_ACK on `ready_and_i`.
  - WAIT_ACK: `ready_and_o`=1. On `valid_i` (data ignored) → IDLE.
- In IDLE, `rx_interrupt_pending_i` is sampled only after the ack response has been consumed, so a stale pending level cannot cause a double read.
- The index counter is BSG_SAFE_CLOG2(max_pkt_bytes_p/(data_width_p/8)) bits wide and never wraps, because the size check bounds it.
- Bytes past the frame end in the last word are passed through unmasked from `read_data_i`.

## Timing
- Reset values: every valid/enable output (`read_en_o`, `write_en_o`, `ready_and_o`, `pkt_v_o`, `pkt_last_o`) is 0. `addr_o`=0, `write_data_o`=0, `pkt_data_o`=0, `drop_count_o`=0, state=IDLE.
- Request signals are registered and held stable until `ready_and_i`. They drop in the cycle after acceptance.
- `pkt_data_o` is registered and held stable while `pkt_v_o`=1 and `pkt_ready_and_i`=0.
- With zero-latency responder and consumer, each data word takes 3 cycles (REQ, WAIT, SEND). A frame of N words takes 3N+5 cycles from pending to IDLE.
- `reset_i` mid-frame returns to IDLE the next cycle. Because the controller shares the reset, no outstanding response survives it.
- `rx_interrupt_pending_i` deasserting mid-frame has no effect; the frame completes.

## Configuration
- `ETH_RX_READER_KEEP_EN` defined:
  - adds output `pkt_keep_o` [data_width_p/8], a byte-enable mask.
  - It is all ones on non-last words.
  - On the last word it has the low (size mod bytes-per-word) bits set, or all ones when that remainder is 0.
- Undefined: the port is absent and the consumer derives frame length itself.

## Structure
- Package `ethernet_rx_reader_pkg`: the state enum and the constants RX_BUF_BASE, RX_SIZE_ADDR, RX_ACK_ADDR, RX_ACK_VAL.
- No sub-module is needed; the saturating drop counter is an inline `bsg_counter_clear_up`-style register.

## Test plan
- Pending with size=6, data_width_p=32:
  - reads 0x1004, then 0x0000 and 0x0004;
  - two stream words, with `pkt_last_o` on the second;
  - `pkt_keep_o`=4'b0011 on the last word when KEEP is enabled;
  - then a write of 1 to 0x1010.
- size=0 → no stream beats, only the ack write; `drop_count_o` stays 0.
- size=3000 → no data reads, ack issued, `drop_count_o`=1. After 300 such frames it reads 255.
- Random `ready_and_i`, `valid_i`, and `pkt_ready_and_i` stalls on a 64-byte frame:
  - exactly 16 words, in address order;
  - request and stream outputs stable throughout every stall.
- `reset_i` pulsed in SEND of word 3 of 10:
  - next cycle all outputs are at reset values;
  - a new pending restarts the sequence at the 0x1004 read.
- Pending held high across the ack → the next frame's size read follows only after the ack response; no duplicate reads.
